mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_DM_STREAK, default 4, consecutive data grants allowed while fetch waits.
REQ-004 SHALL have port clock_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port if_req_i  in  1  instruction-fetch request, level, held until if_gnt_o.
REQ-007 SHALL have port if_addr_i  in  ADDR_W  fetch address, stable while if_req_i high.
REQ-008 SHALL have port if_gnt_o / if_rvalid_o / if_stall_o  out  1 each  fetch grant pulse / read-data valid pulse / waiting indicator.
REQ-009 SHALL have port if_rdata_o  out  DATA_W  fetch read data.
REQ-010 SHALL have port dm_req_i / dm_we_i  in  1 each  data request (level, held until grant) / 1 = store.
REQ-011 SHALL have port dm_addr_i / dm_wdata_i  in  ADDR_W / DATA_W  data address / store data, stable while dm_req_i high.
REQ-012 SHALL have port dm_gnt_o / dm_rvalid_o / dm_stall_o  out  1 each; dm_rdata_o  out  DATA_W.
REQ-013 SHALL have port ram_adr_o / ram_data_o  out  ADDR_W / DATA_W; ram_we_o  out  1; ram_data_i  in  DATA_W (RAM has a 1-cycle synchronous read).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE_I, ISSUE_D, RESP.
REQ-015 SHALL arbitrate in IDLE and RESP on sampled requests. Next state is ISSUE_D or ISSUE_I when a winner exists, else IDLE.
REQ-016 SHALL give data priority over fetch, except when the streak counter equals MAX_DM_STREAK and if_req_i is high; fetch then wins.
REQ-017 SHALL increment the streak counter on each data grant while if_req_i is high. It clears on a fetch grant or when if_req_i is low; it saturates at MAX_DM_STREAK.
REQ-018 SHALL latch the winner's address, we and wdata into registers at arbitration. In ISSUE_x it drives ram_adr_o/ram_data_o from those registers and asserts the matching gnt_o for exactly one cycle.
REQ-019 SHALL assert ram_we_o only in ISSUE_D with a latched store, gated combinationally by reset_i.
REQ-020 SHALL move from every ISSUE_x to RESP. In RESP it captures ram_data_i into the requester's rdata register for reads only.
REQ-021 SHALL pulse the matching rvalid_o for one cycle in the cycle after RESP (grant cycle G, rvalid at G+2); stores produce no rvalid.
REQ-022 SHALL hold rdata_o stable between captures.
REQ-023 SHALL sustain peak throughput of one access per 2 cycles; back-to-back grants are at G and G+2.
REQ-024 SHALL drive x_stall_o = x_req_i & ~x_gnt_o combinationally.
REQ-025 SHALL require that a requester does not drop req before grant; behaviour if it does is undefined.
REQ-026 SHALL grant data when both requests rise in the same cycle, unless the streak is saturated.
REQ-027 SHALL drive ram_adr_o with zero and ram_we_o with 0 when idle.

Reset
REQ-028 SHALL, on reset_i low at a rising edge, set state to IDLE, all gnt/rvalid outputs to 0, rdata registers to 0, streak to 0 and latched registers to 0.
REQ-029 SHALL abandon any in-flight access on reset mid-operation: no rvalid is issued, and ram_we_o is 0 in any cycle where reset_i is low.

Structure
REQ-030 SHALL place state encoding, ADDR_W/DATA_W defaults and the MAX_DM_STREAK default in a shared package dlx_mem_pkg.
REQ-031 SHALL be a single module with no sub-module; the streak counter is inline.

Verification
REQ-032 SHALL cover a single fetch: if_req at cycle 0, addr 0x10, RAM word 0xDEADBEEF -> if_gnt at cycle 1, if_rvalid at cycle 3 with if_rdata 0xDEADBEEF.
REQ-033 SHALL cover a store then load: store 0x20 <- 0x12345678 then load 0x20 -> ram_we_o high one cycle, no dm_rvalid for the store, load returns 0x12345678.
REQ-034 SHALL cover simultaneous requests: if_req and dm_req both rise at cycle 0 -> dm_gnt first, if_gnt two cycles later, if_stall high until then.
REQ-035 SHALL cover fairness: dm_req held for 6 accesses with if_req high -> grants D,D,D,D,I,D.
REQ-036 SHALL cover reset during a store: reset_i low during ISSUE_D -> ram_we_o 0 that cycle, state IDLE, no rvalid, all outputs 0.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// rtl/dlx_mem_pkg.sv - shared widths, streak limit and state encoding for the memory port arbiter
package dlx_mem_pkg;

  localparam int ADDR_W_DEF        = 32;
  localparam int DATA_W_DEF        = 32;
  localparam int MAX_DM_STREAK_DEF = 4;

  // One access occupies ISSUE_x (RAM sees the address) then RESP (RAM data returns).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_I = 2'd1,
    ISSUE_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter in front of a single synchronous-read RAM
module mem_port_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic              if_stall_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic              dm_stall_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int                STREAK_W   = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [STREAK_W-1:0] streak;
  logic                arb_en;
  logic                fetch_forced;
  logic                win_d;
  logic                win_i;
  logic                issuing;

  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_we;
  owner_t              lat_owner;

  logic [DATA_W-1:0]   if_rdata;
  logic [DATA_W-1:0]   dm_rdata;
  logic                if_rvalid;
  logic                dm_rvalid;

  // Pick a winner whenever the RAM is free; data wins unless fetch has waited out a full streak.
  always_comb begin
    arb_en       = 1'b0;
    fetch_forced = 1'b0;
    win_d        = 1'b0;
    win_i        = 1'b0;
    arb_en       = (state == IDLE) || (state == RESP);
    fetch_forced = if_req_i && (streak == STREAK_MAX);
    win_d        = arb_en && dm_req_i && !fetch_forced;
    win_i        = arb_en && if_req_i && !win_d;
  end

  // Next-state logic: arbitrate in IDLE/RESP, every issue cycle is followed by RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: begin
        if (win_d) begin
          state_next = ISSUE_D;
        end else if (win_i) begin
          state_next = ISSUE_I;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE_I, ISSUE_D: state_next = RESP;
      default:          state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's request at arbitration so requesters may move on after their grant.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_owner <= OWN_IF;
    end else if (win_d) begin
      lat_addr  <= dm_addr_i;
      lat_wdata <= dm_wdata_i;
      lat_we    <= dm_we_i;
      lat_owner <= OWN_DM;
    end else if (win_i) begin
      lat_addr  <= if_addr_i;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_owner <= OWN_IF;
    end
  end

  // Count data grants that overtook a waiting fetch; any moment without a waiting fetch restarts the count.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      streak <= '0;
    end else if (!if_req_i || win_i) begin
      streak <= '0;
    end else if (win_d && (streak != STREAK_MAX)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  // Return read data to its owner one cycle after RESP; stores return nothing.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if ((state == RESP) && !lat_we) begin
        if (lat_owner == OWN_DM) begin
          dm_rdata  <= ram_data_i;
          dm_rvalid <= 1'b1;
        end else begin
          if_rdata  <= ram_data_i;
          if_rvalid <= 1'b1;
        end
      end
    end
  end

  assign issuing     = (state == ISSUE_I) || (state == ISSUE_D);
  assign if_gnt_o    = (state == ISSUE_I);
  assign dm_gnt_o    = (state == ISSUE_D);
  assign if_stall_o  = if_req_i & ~if_gnt_o;
  assign dm_stall_o  = dm_req_i & ~dm_gnt_o;
  assign if_rvalid_o = if_rvalid;
  assign dm_rvalid_o = dm_rvalid;
  assign if_rdata_o  = if_rdata;
  assign dm_rdata_o  = dm_rdata;

  // The RAM bus is parked at zero outside issue cycles; a write is killed the moment reset drops.
  assign ram_adr_o  = issuing ? lat_addr : '0;
  assign ram_data_o = issuing ? lat_wdata : '0;
  assign ram_we_o   = (state == ISSUE_D) && lat_we && reset_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - random and directed checks of mem_port_arbiter against a cycle-level reference model
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt_o, if_rvalid_o, if_stall_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt_o, dm_rvalid_o, dm_stall_o;
  logic [DW-1:0] dm_rdata_o;
  logic [AW-1:0] ram_adr_o;
  logic [DW-1:0] ram_data_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_data_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_stall_o(if_stall_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_stall_o(dm_stall_o), .dm_rdata_o(dm_rdata_o),
    .ram_adr_o(ram_adr_o), .ram_data_o(ram_data_o), .ram_we_o(ram_we_o), .ram_data_i(ram_data_i)
  );

  always #5 clock_i = ~clock_i;

  // Synchronous-read RAM seen by the arbiter.
  logic [DW-1:0] ram [0:255];
  always @(posedge clock_i) begin
    if (ram_we_o) ram[ram_adr_o[7:0]] <= ram_data_o;
    ram_data_i <= ram[ram_adr_o[7:0]];
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          if_q[$];
  txn_t          dm_q[$];
  logic [DW-1:0] ref_mem [0:255];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            streak_m = 0;
  bit            g_prev = 0;
  bit            d1_if = 0, d2_if = 0, d1_dm = 0, d2_dm = 0;
  logic [DW-1:0] d1_if_data, d2_if_data, d1_dm_data, d2_dm_data;
  logic [DW-1:0] last_if_rd = '0, last_dm_rd = '0;
  bit            st_pend = 0;
  logic [7:0]    st_addr;
  logic [DW-1:0] st_data;

  string         order = "";
  int            if_gnt_cyc = 0, dm_gnt_cyc = 0, if_rv_cyc = 0;
  int            we_cnt = 0, dm_rv_cnt = 0, if_stall_cnt = 0;
  logic [DW-1:0] if_rv_data = '0, dm_rv_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we   = we;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  task automatic drive();
    if (if_q.size() > 0) begin
      if_req  = 1'b1;
      if_addr = if_q[0].addr;
    end else begin
      if_req  = 1'b0;
      if_addr = '0;
    end
    if (dm_q.size() > 0) begin
      dm_req   = 1'b1;
      dm_we    = dm_q[0].we;
      dm_addr  = dm_q[0].addr;
      dm_wdata = dm_q[0].data;
    end else begin
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
    end
  endtask

  // One clock: predict from the inputs held during the ending cycle, compare, then let requesters react.
  task automatic step();
    bit            p_if, p_dm, p_rst, p_we, arb, wd, wi, e_if_rv, e_dm_rv;
    logic [AW-1:0] p_ia, p_da;
    logic [DW-1:0] p_wd, e_if_rd, e_dm_rd;
    p_if = if_req; p_dm = dm_req; p_rst = reset_i; p_we = dm_we;
    p_ia = if_addr; p_da = dm_addr; p_wd = dm_wdata;
    @(posedge clock_i);
    #1;
    cyc++;
    if (st_pend && p_rst) ref_mem[st_addr] = st_data;
    st_pend = 0;
    arb = p_rst && !g_prev && (p_if || p_dm);
    wd  = arb && p_dm && !(p_if && streak_m == MAXS);
    wi  = arb && !wd && p_if;
    if (!p_rst || wi || !p_if) streak_m = 0;
    else if (wd && streak_m < MAXS) streak_m++;
    g_prev = wd || wi;
    if (!p_rst) begin
      d1_if = 0; d2_if = 0; d1_dm = 0; d2_dm = 0;
      last_if_rd = '0; last_dm_rd = '0;
    end
    e_if_rv = d2_if; e_if_rd = d2_if_data;
    e_dm_rv = d2_dm; e_dm_rd = d2_dm_data;
    d2_if = d1_if; d2_if_data = d1_if_data;
    d2_dm = d1_dm; d2_dm_data = d1_dm_data;
    d1_if = wi;          d1_if_data = ref_mem[p_ia[7:0]];
    d1_dm = wd && !p_we; d1_dm_data = ref_mem[p_da[7:0]];
    if (wd && p_we) begin
      st_pend = 1; st_addr = p_da[7:0]; st_data = p_wd;
    end
    if (e_if_rv) last_if_rd = e_if_rd;
    if (e_dm_rv) last_dm_rd = e_dm_rd;

    chk("if_gnt", if_gnt_o, wi);
    chk("dm_gnt", dm_gnt_o, wd);
    chk("if_stall", if_stall_o, p_if && !wi);
    chk("dm_stall", dm_stall_o, p_dm && !wd);
    chk("ram_we", ram_we_o, wd && p_we && reset_i);
    chk("ram_adr", ram_adr_o, wd ? p_da : (wi ? p_ia : '0));
    if (wd && p_we) chk("ram_data", ram_data_o, p_wd);
    if (!(wd || wi)) chk("ram_data_idle", ram_data_o, 0);
    chk("if_rvalid", if_rvalid_o, e_if_rv);
    chk("dm_rvalid", dm_rvalid_o, e_dm_rv);
    chk("if_rdata", if_rdata_o, last_if_rd);
    chk("dm_rdata", dm_rdata_o, last_dm_rd);

    if (if_gnt_o) begin order = {order, "I"}; if_gnt_cyc = cyc; end
    if (dm_gnt_o) begin order = {order, "D"}; dm_gnt_cyc = cyc; end
    if (if_rvalid_o) begin if_rv_cyc = cyc; if_rv_data = if_rdata_o; end
    if (dm_rvalid_o) begin dm_rv_cnt++; dm_rv_data = dm_rdata_o; end
    if (ram_we_o) we_cnt++;
    if (if_stall_o) if_stall_cnt++;

    if (wi && if_q.size() > 0) void'(if_q.pop_front());
    if (wd && dm_q.size() > 0) void'(dm_q.pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((if_q.size() > 0 || dm_q.size() > 0 || g_prev || d1_if || d1_dm || d2_if || d2_dm)
           && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, (n < max_cyc), 1);
  endtask

  initial begin
    int            c0, we0, rv0, s0;
    logic [DW-1:0] old5;

    reset_i = 1'b0;
    drive();
    step();
    step();
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_dm_gnt", dm_gnt_o, 0);
    chk("rst_if_rvalid", if_rvalid_o, 0);
    chk("rst_dm_rvalid", dm_rvalid_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);
    chk("rst_ram_adr", ram_adr_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    reset_i = 1'b1;
    step();

    // Fill the working address range with known words.
    for (int a = 0; a < 32; a++) dm_q.push_back(mk(1'b1, AW'(a), 32'hC0DE0000 | DW'(a)));
    drive();
    drain("preload_bound", 200);

    // Single fetch returning 0xDEADBEEF.
    dm_q.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
    drive();
    drain("fetch_setup_bound", 20);
    step();
    c0 = cyc;
    if_q.push_back(mk(1'b0, 32'h10, '0));
    drive();
    drain("fetch_bound", 20);
    chk("fetch_gnt_cycle", if_gnt_cyc - c0, 1);
    chk("fetch_rvalid_cycle", if_rv_cyc - c0, 3);
    chk("fetch_rdata", if_rv_data, 32'hDEADBEEF);
    step();

    // Store then load of the same word.
    we0 = we_cnt;
    rv0 = dm_rv_cnt;
    dm_q.push_back(mk(1'b1, 32'h20, 32'h12345678));
    drive();
    drain("store_bound", 20);
    chk("store_we_cycles", we_cnt - we0, 1);
    chk("store_no_rvalid", dm_rv_cnt - rv0, 0);
    dm_q.push_back(mk(1'b0, 32'h20, '0));
    drive();
    drain("load_bound", 20);
    chk("load_rvalid_count", dm_rv_cnt - rv0, 1);
    chk("load_rdata", dm_rv_data, 32'h12345678);
    step();

    // Both requests rise together.
    c0 = cyc;
    s0 = if_stall_cnt;
    if_q.push_back(mk(1'b0, 32'h10, '0));
    dm_q.push_back(mk(1'b0, 32'h20, '0));
    drive();
    #1;
    chk("simul_stall_c0", if_stall_o, 1);
    drain("simul_bound", 20);
    chk("simul_dm_gnt_cycle", dm_gnt_cyc - c0, 1);
    chk("simul_if_gnt_cycle", if_gnt_cyc - c0, 3);
    chk("simul_stall_cycles", if_stall_cnt - s0, 2);
    step();

    // Fairness: five data accesses and one waiting fetch.
    order = "";
    for (int k = 0; k < 5; k++) dm_q.push_back(mk(1'b0, AW'(k), '0));
    if_q.push_back(mk(1'b0, 32'h3, '0));
    drive();
    drain("fair_bound", 40);
    total++;
    assert (order == "DDDDID") else begin
      bad++;
      $error("FAIL fair_order: observed=%s expected=DDDDID", order);
    end
    step();

    // Reset while a store is in its issue cycle.
    old5 = ref_mem[5];
    rv0  = dm_rv_cnt;
    dm_q.push_back(mk(1'b1, 32'h5, 32'hA5A5A5A5));
    drive();
    step();
    chk("rst_store_gnt", dm_gnt_o, 1);
    reset_i = 1'b0;
    if_q.delete();
    dm_q.delete();
    drive();
    #1;
    chk("rst_store_we_gated", ram_we_o, 0);
    step();
    chk("rst_store_gnt_after", dm_gnt_o, 0);
    chk("rst_store_adr_after", ram_adr_o, 0);
    chk("rst_store_rdata_after", if_rdata_o, 0);
    reset_i = 1'b1;
    step(); step(); step();
    chk("rst_store_no_rvalid", dm_rv_cnt - rv0, 0);
    dm_q.push_back(mk(1'b0, 32'h5, '0));
    drive();
    drain("rst_reload_bound", 20);
    chk("rst_store_not_written", dm_rv_data, old5);

    // Reset while a load is in RESP: its return is dropped.
    rv0 = dm_rv_cnt;
    dm_q.push_back(mk(1'b0, 32'h7, '0));
    drive();
    step();
    step();
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    step(); step(); step();
    chk("rst_load_no_rvalid", dm_rv_cnt - rv0, 0);

    // Random traffic on both ports.
    for (int i = 0; i < 500; i++) begin
      if (if_q.size() == 0 && $urandom_range(0, 3) != 0)
        if_q.push_back(mk(1'b0, AW'($urandom_range(0, 31)), '0));
      if (dm_q.size() == 0 && $urandom_range(0, 4) != 0)
        dm_q.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom)));
      drive();
      step();
    end
    drain("random_bound", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
